// File: rtl/psram_qpi_ctrl.sv
// psram_qpi_ctrl: single-beat 32-bit controller for a QPI PSRAM.
// After reset it switches the device from SPI to QPI mode, then serves one read or write beat at a time.
module psram_qpi_ctrl #(
  parameter int ADDR_WIDTH  = 23,
  parameter int CE_HIGH_CYC = 2
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_wen_i,
  input  logic [ADDR_WIDTH-3:0] req_addr_i,
  input  logic [3:0]            req_bm_i,
  input  logic [31:0]           req_wdat_i,
  output logic [31:0]           rsp_rdat_o,
  output logic                  rsp_rvalid_o,
  output logic                  rsp_wack_o,
  output logic                  init_done_o,
  output logic                  ce_n_o,
  output logic                  sclk_o,
  output logic [3:0]            dq_o,
  output logic [3:0]            dq_oe_o,
  input  logic [3:0]            dq_i
);
  typedef enum logic [3:0] {INIT_WAIT, INIT_CMD, IDLE, CMD, ADDR, WDATA, RWAIT, RDATA, CE_HIGH} state_t;
  localparam logic [7:0] QPI_ENTER = 8'h35;
  state_t st, nxt;
  logic [7:0] cnt, len, op, wbyte;
  logic [2:0] k;
  logic [1:0] lo, bsel;
  logic [4:0] aidx;
  logic [3:0] bm_q, rest;
  logic [31:0] wdat_q, rdat_q;
  logic [ADDR_WIDTH-3:0] addr_q;
  logic [23:0] baddr;
  logic wen_q, init_done_q, wack0_q, full, last, accept, active;
  // cnt counts aclk within a state; its LSB is the sclk phase, cnt[3:1] the nibble slot
  always_comb begin
    k = cnt[3:1];
    full = bm_q == 4'hF;
    lo = bm_q[0] ? 2'd0 : bm_q[1] ? 2'd1 : bm_q[2] ? 2'd2 : 2'd3;
    rest = full ? 4'h0 : bm_q & ~(4'b0001 << lo);
    bsel = full ? k[2:1] : lo;
    op = wen_q ? 8'h38 : 8'hEB;
    wbyte = wdat_q[{bsel, 3'b000} +: 8];
    baddr = 24'({addr_q, (wen_q && !full) ? lo : 2'b00});
    aidx = 5'd20 - {k, 2'b00};
    len = (st == INIT_WAIT || st == INIT_CMD || st == RDATA || (st == WDATA && full)) ? 8'd16 :
          (st == CMD || st == WDATA) ? 8'd4 :
          (st == ADDR || st == RWAIT) ? 8'd12 : 8'(CE_HIGH_CYC);
    last = cnt == len - 8'd1;
    accept = req_valid_i && req_ready_o;
  end
  always_comb begin
    nxt = st;
    case (st)
      INIT_WAIT: if (last) nxt = INIT_CMD;
      INIT_CMD:  if (last) nxt = CE_HIGH;
      IDLE:      if (accept && !(req_wen_i && req_bm_i == 4'h0)) nxt = CMD;
      CMD:       if (last) nxt = ADDR;
      ADDR:      if (last) nxt = wen_q ? WDATA : RWAIT;
      WDATA:     if (last) nxt = CE_HIGH;
      RWAIT:     if (last) nxt = RDATA;
      RDATA:     if (last) nxt = CE_HIGH;
      CE_HIGH:   if (last) nxt = (wen_q && rest != 4'h0) ? CMD : IDLE;
      default:   nxt = INIT_WAIT;
    endcase
  end
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      st <= INIT_WAIT;
      cnt <= '0;
      init_done_q <= 1'b0;
      wack0_q <= 1'b0;
      wen_q <= 1'b0;
      addr_q <= '0;
      bm_q <= '0;
      wdat_q <= '0;
      rdat_q <= '0;
    end else begin
      st <= nxt;
      cnt <= (nxt == st) ? cnt + 8'd1 : 8'd0;
      if (nxt == IDLE) init_done_q <= 1'b1;
      wack0_q <= accept && req_wen_i && req_bm_i == 4'h0;
      if (accept) begin
        wen_q <= req_wen_i;
        addr_q <= req_addr_i;
        bm_q <= req_bm_i;
        wdat_q <= req_wdat_i;
      end else if (st == CE_HIGH && last) bm_q <= rest;
      if (st == RDATA && cnt[0]) rdat_q[{k[2:1], ~k[0], 2'b00} +: 4] <= dq_i;
    end
  assign active = st inside {INIT_CMD, CMD, ADDR, WDATA, RWAIT, RDATA};
  assign ce_n_o = !active;
  assign sclk_o = active && cnt[0];
  assign dq_oe_o = (st == INIT_CMD) ? 4'b0001 : (st inside {CMD, ADDR, WDATA}) ? 4'hF : 4'h0;
  assign dq_o = (st == INIT_CMD) ? {3'b000, QPI_ENTER[3'd7 - k]} :
                (st == CMD) ? (k[0] ? op[3:0] : op[7:4]) :
                (st == ADDR) ? baddr[aidx +: 4] :
                (st == WDATA) ? (k[0] ? wbyte[3:0] : wbyte[7:4]) : 4'h0;
  assign req_ready_o = st == IDLE && init_done_q;
  assign rsp_rvalid_o = st == CE_HIGH && cnt == 8'd0 && !wen_q && init_done_q;
  assign rsp_wack_o = wack0_q || (st == CE_HIGH && last && wen_q && rest == 4'h0);
  assign init_done_o = init_done_q;
  assign rsp_rdat_o = rdat_q;
endmodule

// File: tb/tb_psram_qpi_ctrl.sv
// tb_psram_qpi_ctrl: directed beats against a PSRAM pin model; frames and responses are
// checked by a negedge monitor that pops expectations queued by the stimulus thread.
module tb_psram_qpi_ctrl;
  localparam int CE_HIGH_CYC = 2;
  typedef struct {logic [63:0] n; int len;} frame_t;
  typedef struct {bit rd; logic [31:0] d; int due;} rsp_t;
  logic aclk = 1'b0, areset, req_valid_i, req_ready_o, req_wen_i;
  logic [20:0] req_addr_i;
  logic [3:0] req_bm_i, dq_o, dq_oe_o;
  logic [3:0] dq_i = 4'h0;
  logic [31:0] req_wdat_i, rsp_rdat_o;
  logic rsp_rvalid_o, rsp_wack_o, init_done_o, ce_n_o, sclk_o;
  int checks = 0, failures = 0, cyc = 0, sc = 0, fl = 0, gap = 100;
  logic [31:0] dev = 32'h0;
  logic [63:0] fv = '0;
  logic ce_prev = 1'b1;
  frame_t fq[$];
  rsp_t rq[$];
  frame_t mf;
  rsp_t mr;

  psram_qpi_ctrl #(.ADDR_WIDTH(23), .CE_HIGH_CYC(CE_HIGH_CYC)) dut (
    .aclk(aclk), .areset(areset), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_wen_i(req_wen_i), .req_addr_i(req_addr_i), .req_bm_i(req_bm_i), .req_wdat_i(req_wdat_i),
    .rsp_rdat_o(rsp_rdat_o), .rsp_rvalid_o(rsp_rvalid_o), .rsp_wack_o(rsp_wack_o),
    .init_done_o(init_done_o), .ce_n_o(ce_n_o), .sclk_o(sclk_o), .dq_o(dq_o),
    .dq_oe_o(dq_oe_o), .dq_i(dq_i)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  // device model: read data nibbles follow opcode(2) + address(6) + wait(6) sclk
  always @(posedge sclk_o or posedge ce_n_o)
    if (ce_n_o) sc = 0;
    else begin
      sc++;
      if (sc >= 15 && sc <= 22) dq_i = 4'(dev >> (4 * (22 - sc)));
    end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic exp_frame(input logic [63:0] n, input int len);
    fq.push_back('{n, len});
  endtask

  task automatic exp_rsp(input bit rd, input logic [31:0] d, input int due);
    rq.push_back('{rd, d, due});
  endtask

  always @(negedge aclk)
    if (areset) begin
      fv = '0;
      fl = 0;
      gap = 100;
      ce_prev = 1'b1;
    end else begin
      if (ce_n_o) check("idle_pins", {sclk_o, dq_oe_o}, 5'h0);
      if (!ce_n_o && sclk_o && dq_oe_o != 4'h0) begin
        fv = {fv[59:0], dq_o};
        fl++;
      end
      if (ce_prev && !ce_n_o) check("ce_high_gap", gap >= CE_HIGH_CYC, 1);
      gap = ce_n_o ? gap + 1 : 0;
      if (!ce_prev && ce_n_o) begin
        if (fq.size() == 0) check("frame_unexpected", fv, 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          mf = fq.pop_front();
          check("frame_nibbles", fv, mf.n);
          check("frame_len", fl, mf.len);
        end
        fv = '0;
        fl = 0;
      end
      ce_prev = ce_n_o;
      if (rsp_rvalid_o || rsp_wack_o) begin
        if (rq.size() == 0) check("rsp_unexpected", {rsp_rvalid_o, rsp_wack_o}, 2'b00);
        else begin
          mr = rq.pop_front();
          check("rsp_kind", {rsp_rvalid_o, rsp_wack_o}, mr.rd ? 2'b10 : 2'b01);
          if (mr.rd) check("rsp_rdat", rsp_rdat_o, mr.d);
          check("rsp_cycle", cyc, mr.due);
        end
      end
    end

  task automatic issue(input logic wen, input logic [20:0] addr, input logic [3:0] bm,
                       input logic [31:0] wdat, output int acc);
    int n = 0;
    req_valid_i = 1'b1;
    req_wen_i = wen;
    req_addr_i = addr;
    req_bm_i = bm;
    req_wdat_i = wdat;
    while (!req_ready_o && n < 200) begin
      @(posedge aclk); #1;
      n++;
    end
    check("ready_wait", req_ready_o, 1);
    @(posedge aclk); #1;
    acc = cyc;
    req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((fq.size() != 0 || rq.size() != 0 || !req_ready_o) && n < 1000) begin
      @(posedge aclk); #1;
      n++;
    end
    check("drain", n < 1000, 1);
  endtask

  task automatic release_and_init();
    int n = 0;
    exp_frame(64'h00110101, 8);
    areset = 1'b0;
    while (ce_n_o && n < 100) begin
      @(posedge aclk); #1;
      n++;
    end
    check("init_wait_cycles", n, 16);
    check("ready_during_init", req_ready_o, 0);
    n = 0;
    while (!init_done_o && n < 100) begin
      @(posedge aclk); #1;
      n++;
    end
    check("init_done", init_done_o, 1);
  endtask

  initial begin
    int acc, acc2;
    areset = 1'b1;
    req_valid_i = 1'b0;
    req_wen_i = 1'b0;
    req_addr_i = '0;
    req_bm_i = '0;
    req_wdat_i = '0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("reset_pins", {ce_n_o, sclk_o, dq_o, dq_oe_o, req_ready_o, rsp_rvalid_o, rsp_wack_o, init_done_o}, 14'h2000);
    check("reset_rdat", rsp_rdat_o, 32'h0);
    @(posedge aclk); #1;
    release_and_init();
    issue(1'b1, 21'h10, 4'hF, 32'hDDCCBBAA, acc);
    exp_frame(64'h38000040AABBCCDD, 16);
    exp_rsp(1'b0, 32'h0, acc + 33);
    drain();
    issue(1'b1, 21'h1, 4'b1010, 32'h44332211, acc);
    exp_frame(64'h3800000522, 10);
    exp_frame(64'h3800000744, 10);
    exp_rsp(1'b0, 32'h0, acc + 43);
    drain();
    issue(1'b1, 21'h1FFFFF, 4'b1000, 32'h5A000000, acc);
    exp_frame(64'h387FFFFF5A, 10);
    exp_rsp(1'b0, 32'h0, acc + 21);
    drain();
    dev = 32'h12345678;
    issue(1'b0, 21'h2, 4'h0, 32'h0, acc);
    exp_frame(64'hEB000008, 8);
    exp_rsp(1'b1, 32'h78563412, acc + 44);
    drain();
    check("rdat_held", rsp_rdat_o, 32'h78563412);
    dev = 32'hA5C30F96;
    issue(1'b0, 21'h1FFFFF, 4'h0, 32'h0, acc);
    exp_frame(64'hEB7FFFFC, 8);
    exp_rsp(1'b1, 32'h960FC3A5, acc + 44);
    drain();
    dev = 32'h0F1E2D3C;
    issue(1'b0, 21'h3, 4'h0, 32'h0, acc);
    exp_frame(64'hEB00000C, 8);
    exp_rsp(1'b1, 32'h3C2D1E0F, acc + 44);
    issue(1'b1, 21'h7, 4'h0, 32'hFFFFFFFF, acc2);
    exp_rsp(1'b0, 32'h0, acc2);
    check("b2b_accept_gap", acc2 - acc, 47);
    drain();
    issue(1'b1, 21'h20, 4'hF, 32'h12345678, acc);
    repeat (8) @(posedge aclk);
    #1;
    check("abort_pre_ce", ce_n_o, 0);
    areset = 1'b1;
    #1;
    check("abort_pins", {ce_n_o, sclk_o, dq_oe_o, init_done_o, req_ready_o}, 8'h80);
    repeat (2) @(posedge aclk);
    #1;
    release_and_init();
    issue(1'b1, 21'h3, 4'hF, 32'h01234567, acc);
    exp_frame(64'h3800000C67452301, 16);
    exp_rsp(1'b0, 32'h0, acc + 33);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
